// File: rtl/mips_mc_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control_if
// Brief    : Opcode/handshake inputs and datapath control outputs of the
//            multi-cycle MIPS controller.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_mc_control_if;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       IllegalOp;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] State;

    // The controller side drives the control word and reads opcode/handshake.
    modport master (
        input  Op, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp,
               ALUOp, ALUSrcB, PCSource, State
    );

    modport slave (
        output Op, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp,
               ALUOp, ALUSrcB, PCSource, State
    );
endinterface
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control
// Brief    : Multi-cycle MIPS control FSM. Optional addi support is enabled
//            by defining MIPS_MC_CONTROL_ADDI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control (
    input  wire logic         clk,
    input  wire logic         reset,
    mips_mc_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        JEX     = 4'd9
`ifdef MIPS_MC_CONTROL_ADDI_EN
        ,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_MC_CONTROL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'h08;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    // Pure Moore part of the control word; the MemReady/Op-dependent bits are added below.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
            MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
            EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            RTYPEWB: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BEQEX:   begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            JEX:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
`ifdef MIPS_MC_CONTROL_ADDI_EN
            ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDIWB:  c.reg_write = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (bus.MemReady) state_d = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
`ifdef MIPS_MC_CONTROL_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (bus.Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (bus.MemReady) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (bus.MemReady) state_d = FETCH;
            EXEC:    state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BEQEX:   state_d = FETCH;
            JEX:     state_d = FETCH;
`ifdef MIPS_MC_CONTROL_ADDI_EN
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Control word is registered alongside the state so it is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= decode_state(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_state(state_d);
        end
    end

    logic w_fetch;
    logic w_decode;
    logic w_op_legal;
    logic w_run;

    assign w_fetch  = (state_q == FETCH);
    assign w_decode = (state_q == DECODE);
    assign w_run    = ~reset;

    always_comb begin
        case (bus.Op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: w_op_legal = 1'b1;
`ifdef MIPS_MC_CONTROL_ADDI_EN
            OP_ADDI:                              w_op_legal = 1'b1;
`endif
            default:                              w_op_legal = 1'b0;
        endcase
    end

    // Reset forces every output low so no write enable can fire during reset.
    assign bus.PCWrite     = w_run & (ctrl_q.pc_write | (w_fetch & bus.MemReady));
    assign bus.IRWrite     = w_run & w_fetch & bus.MemReady;
    assign bus.IllegalOp   = w_run & w_decode & ~w_op_legal;
    assign bus.PCWriteCond = w_run & ctrl_q.pc_write_cond;
    assign bus.IorD        = w_run & ctrl_q.iord;
    assign bus.MemRead     = w_run & ctrl_q.mem_read;
    assign bus.MemWrite    = w_run & ctrl_q.mem_write;
    assign bus.MemtoReg    = w_run & ctrl_q.mem_to_reg;
    assign bus.ALUSrcA     = w_run & ctrl_q.alu_src_a;
    assign bus.RegWrite    = w_run & ctrl_q.reg_write;
    assign bus.RegDst      = w_run & ctrl_q.reg_dst;
    assign bus.ALUOp       = w_run ? ctrl_q.alu_op    : 2'b00;
    assign bus.ALUSrcB     = w_run ? ctrl_q.alu_src_b : 2'b00;
    assign bus.PCSource    = w_run ? ctrl_q.pc_source : 2'b00;
    assign bus.State       = w_run ? state_q          : 4'd0;
endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_control
// Brief    : Self-checking bench for mips_mc_control: vector table, directed
//            multi-cycle sequences and randomized instruction streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_control;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mips_mc_control_if bus ();

    mips_mc_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: current step number plus the remaining steps of the instruction.
    int m_state = 0;
    int m_q[$];

    function automatic bit legal_op(input logic [5:0] op);
`ifdef MIPS_MC_CONTROL_ADDI_EN
        return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
`else
        return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02};
`endif
    endfunction

    function automatic void load_seq(input logic [5:0] op);
        m_q = {};
        case (op)
            6'h23:   m_q = {1, 2, 3, 4};
            6'h2B:   m_q = {1, 2, 5};
            6'h00:   m_q = {1, 6, 7};
            6'h04:   m_q = {1, 8};
            6'h02:   m_q = {1, 9};
`ifdef MIPS_MC_CONTROL_ADDI_EN
            6'h08:   m_q = {1, 10, 11};
`endif
            default: m_q = {1};
        endcase
    endfunction

    function automatic void model_advance(input logic r, input logic mr, input logic [5:0] op);
        if (r) begin
            m_state = 0;
            m_q     = {};
        end else if (m_state == 0) begin
            if (mr) begin
                load_seq(op);
                m_state = m_q.pop_front();
            end
        end else if ((m_state == 3 || m_state == 5) && !mr) begin
            m_state = m_state;
        end else begin
            m_state = (m_q.size() > 0) ? m_q.pop_front() : 0;
        end
    endfunction

    // {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
    //  ALUSrcA, RegWrite, RegDst, IllegalOp, ALUOp, ALUSrcB, PCSource}
    function automatic logic [20:0] model_out(input int st, input logic r, input logic mr,
                                              input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, ill;
        logic [1:0] aop, sb, ps;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, ill} = '0;
        aop = 2'd0; sb = 2'd0; ps = 2'd0;
        if (!r) begin
            case (st)
                0:  begin mrd = 1; sb = 2'd1; pcw = mr; irw = mr; end
                1:  begin sb = 2'd3; ill = !legal_op(op); end
                2:  begin srca = 1; sb = 2'd2; end
                3:  begin mrd = 1; iord = 1; end
                4:  begin rw = 1; m2r = 1; end
                5:  begin mwr = 1; iord = 1; end
                6:  begin srca = 1; aop = 2'd2; end
                7:  begin rw = 1; rd = 1; end
                8:  begin srca = 1; aop = 2'd1; pcwc = 1; ps = 2'd1; end
                9:  begin pcw = 1; ps = 2'd2; end
                10: begin srca = 1; sb = 2'd2; end
                11: rw = 1;
                default: ;
            endcase
        end
        return {(r ? 4'd0 : 4'(st)), pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, ill,
                aop, sb, ps};
    endfunction

    task automatic check(input string name, input logic [20:0] exp);
        logic [20:0] act;
        act = {bus.State, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
               bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst, bus.IllegalOp,
               bus.ALUOp, bus.ALUSrcB, bus.PCSource};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare away from the edge, clock, update the model.
    task automatic step(input logic r, input logic [5:0] op, input logic mr,
                        input string name, input logic [20:0] exp);
        reset        = r;
        bus.Op       = op;
        bus.MemReady = mr;
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
        model_advance(r, mr, op);
    endtask

    task automatic mstep(input logic r, input logic [5:0] op, input logic mr, input string name);
        step(r, op, mr, name, model_out(m_state, r, mr, op));
    endtask

    task automatic latency(input logic [5:0] op, input int exp_cyc, input string name);
        int n;
        n = 0;
        do begin
            mstep(1'b0, op, 1'b1, name);
            n++;
        end while (bus.State != 4'd0 && n < 20);
        check_int({name, "_cycles"}, n, exp_cyc);
    endtask

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [10:0] fl;
        logic [1:0]  aop;
        logic [1:0]  sb;
        logic [1:0]  ps;
    } vec_t;

    vec_t tbl[20];

    initial begin
        reset        = 1'b1;
        bus.Op       = 6'h00;
        bus.MemReady = 1'b0;

        // flags: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite ALUSrcA RegWrite RegDst IllegalOp
        tbl[0]  = '{1'b1, 6'h23, 1'b1, 4'd0, 11'b00000000000, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{1'b1, 6'h23, 1'b1, 4'd0, 11'b00000000000, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{1'b0, 6'h23, 1'b1, 4'd0, 11'b10010010000, 2'b00, 2'b01, 2'b00};
        tbl[3]  = '{1'b0, 6'h23, 1'b1, 4'd1, 11'b00000000000, 2'b00, 2'b11, 2'b00};
        tbl[4]  = '{1'b0, 6'h23, 1'b1, 4'd2, 11'b00000001000, 2'b00, 2'b10, 2'b00};
        tbl[5]  = '{1'b0, 6'h23, 1'b1, 4'd3, 11'b00110000000, 2'b00, 2'b00, 2'b00};
        tbl[6]  = '{1'b0, 6'h23, 1'b1, 4'd4, 11'b00000100100, 2'b00, 2'b00, 2'b00};
        tbl[7]  = '{1'b0, 6'h3F, 1'b1, 4'd0, 11'b10010010000, 2'b00, 2'b01, 2'b00};
        tbl[8]  = '{1'b0, 6'h3F, 1'b1, 4'd1, 11'b00000000001, 2'b00, 2'b11, 2'b00};
        tbl[9]  = '{1'b0, 6'h04, 1'b0, 4'd0, 11'b00010000000, 2'b00, 2'b01, 2'b00};
        tbl[10] = '{1'b0, 6'h04, 1'b1, 4'd0, 11'b10010010000, 2'b00, 2'b01, 2'b00};
        tbl[11] = '{1'b0, 6'h04, 1'b1, 4'd1, 11'b00000000000, 2'b00, 2'b11, 2'b00};
        tbl[12] = '{1'b0, 6'h04, 1'b1, 4'd8, 11'b01000001000, 2'b01, 2'b00, 2'b01};
        tbl[13] = '{1'b0, 6'h02, 1'b1, 4'd0, 11'b10010010000, 2'b00, 2'b01, 2'b00};
        tbl[14] = '{1'b0, 6'h02, 1'b1, 4'd1, 11'b00000000000, 2'b00, 2'b11, 2'b00};
        tbl[15] = '{1'b0, 6'h02, 1'b1, 4'd9, 11'b10000000000, 2'b00, 2'b00, 2'b10};
        tbl[16] = '{1'b0, 6'h00, 1'b1, 4'd0, 11'b10010010000, 2'b00, 2'b01, 2'b00};
        tbl[17] = '{1'b0, 6'h00, 1'b1, 4'd1, 11'b00000000000, 2'b00, 2'b11, 2'b00};
        tbl[18] = '{1'b0, 6'h00, 1'b1, 4'd6, 11'b00000001000, 2'b10, 2'b00, 2'b00};
        tbl[19] = '{1'b0, 6'h00, 1'b1, 4'd7, 11'b00000000110, 2'b00, 2'b00, 2'b00};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst, tbl[i].op, tbl[i].mr, $sformatf("vec%0d", i),
                 {tbl[i].st, tbl[i].fl, tbl[i].aop, tbl[i].sb, tbl[i].ps});
        end
        check_int("vec_end_state", int'(bus.State), 0);

        // Reset held two cycles while lw waits in MEMRD.
        mstep(1'b0, 6'h23, 1'b1, "rst_mid_fetch");
        mstep(1'b0, 6'h23, 1'b1, "rst_mid_decode");
        mstep(1'b0, 6'h23, 1'b1, "rst_mid_memadr");
        mstep(1'b0, 6'h23, 1'b0, "rst_mid_memrd_wait");
        check_int("rst_pre_state", int'(bus.State), 3);
        mstep(1'b1, 6'h23, 1'b0, "rst_hold1");
        mstep(1'b1, 6'h23, 1'b0, "rst_hold2");
        reset = 1'b0;
        @(negedge clk);
        check_int("rst_release_memread", int'(bus.MemRead), 1);
        check_int("rst_release_iord", int'(bus.IorD), 0);
        check_int("rst_release_state", int'(bus.State), 0);
        mstep(1'b0, 6'h23, 1'b0, "rst_release_fetch");

        // sw with three wait cycles in MEMWR.
        mstep(1'b0, 6'h2B, 1'b1, "sw_fetch");
        mstep(1'b0, 6'h2B, 1'b1, "sw_decode");
        mstep(1'b0, 6'h2B, 1'b1, "sw_memadr");
        for (int i = 0; i < 4; i++) begin
            bus.MemReady = (i == 3);
            @(negedge clk);
            check_int($sformatf("sw_hold%0d", i),
                      int'({bus.MemWrite, bus.IorD, bus.State}), int'({2'b11, 4'd5}));
            @(posedge clk);
            #1;
            model_advance(1'b0, (i == 3), 6'h2B);
        end
        check_int("sw_done_state", int'(bus.State), 0);

        // Zero-wait latency per instruction class.
        latency(6'h23, 5, "lat_lw");
        latency(6'h2B, 4, "lat_sw");
        latency(6'h00, 4, "lat_rtype");
        latency(6'h04, 3, "lat_beq");
        latency(6'h02, 3, "lat_j");
        latency(6'h3F, 2, "lat_illegal");
`ifdef MIPS_MC_CONTROL_ADDI_EN
        latency(6'h08, 4, "lat_addi");
`else
        latency(6'h08, 2, "lat_addi_illegal");
`endif

        // Randomized instruction stream against the model, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic       r;
            logic       mr;
            int         guard;
            int         sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = 6'h23;
                1: op = 6'h2B;
                2: op = 6'h00;
                3: op = 6'h04;
                4: op = 6'h02;
                5: op = 6'h08;
                6: op = 6'h3F;
                default: op = 6'($urandom);
            endcase
            guard = 0;
            do begin
                r  = ($urandom_range(0, 49) == 0);
                mr = ($urandom_range(0, 3) != 0);
                mstep(r, op, mr, "rand");
                guard++;
            end while (m_state != 0 && guard < 40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: Op  input  6  opcode field of the instruction register.
REQ-004 SHALL have port: MemReady  input  1  memory handshake; 1 = current read/write completes this cycle.
REQ-005 SHALL have outputs, 1 bit each: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp.
REQ-006 SHALL have 2-bit outputs: ALUOp (00 add, 01 subtract, 10 FuncCode-decoded, to the ALU control stage), ALUSrcB, PCSource.
REQ-007 SHALL have port: State  output  4  current state encoding, for debug.

Function
REQ-008 SHALL be a Moore FSM; the only exceptions are IRWrite/PCWrite in FETCH and IllegalOp in DECODE, which also depend on MemReady and Op respectively.
REQ-009 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RTYPEWB 7, BEQEX 8, JEX 9, ADDIEX 10, ADDIWB 11.
REQ-010 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady; it SHALL stay in FETCH while MemReady=0 and go to DECODE when MemReady=1.
REQ-011 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state SHALL be MEMADR for Op 0x23/0x2B, EXEC for 0x00, BEQEX for 0x04, JEX for 0x02, and ADDIEX for 0x08 (see Configuration).
REQ-012 DECODE with any other Op SHALL drive IllegalOp=1 for that cycle and go to FETCH; no register or memory write SHALL occur.
REQ-013 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state SHALL be MEMRD if Op=0x23, else MEMWR.
REQ-014 MEMRD SHALL drive MemRead=1, IorD=1; it SHALL hold until MemReady=1, then go to MEMWB.
REQ-015 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-016 MEMWR SHALL drive MemWrite=1, IorD=1; it SHALL hold until MemReady=1, then go to FETCH.
REQ-017 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RTYPEWB; RTYPEWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-018 BEQEX SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-019 JEX SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-020 Any output not listed for a state SHALL be 0 in that state; an unused State encoding (12-15) SHALL go to FETCH with all outputs 0.
REQ-021 Instruction latency in cycles, with zero memory wait, SHALL be: lw 5, sw 4, R-type 4, beq 3, j 3, addi 4; each MemReady=0 cycle SHALL add one cycle.

Reset
REQ-022 When reset=1 at a clock edge, State SHALL become FETCH regardless of current state, including mid-instruction or mid-wait.
REQ-023 While reset=1, all outputs SHALL be 0 (combinationally forced), so no write enable is active during reset.
REQ-024 On the first cycle after reset deasserts, outputs SHALL be the FETCH values.

Configuration
REQ-025 Macro MIPS_MC_CONTROL_ADDI_EN: when defined, Op 0x08 SHALL go DECODE->ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00)->ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0)->FETCH.
REQ-026 When MIPS_MC_CONTROL_ADDI_EN is undefined, states 10/11 SHALL not exist and Op 0x08 SHALL be treated as illegal per REQ-012.

Verification
REQ-027 Reset high 2 cycles during MEMRD, then low -> State=0 after the edge, all outputs 0 during reset, MemRead=1 and IorD=0 on the first cycle after release.
REQ-028 Op=0x23, MemReady=1 always -> States 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-029 Op=0x2B, MemReady=0 for 3 cycles in MEMWR -> MemWrite=1 and IorD=1 held for 4 cycles, then State=0.
REQ-030 Op=0x00 -> ALUOp=10 in EXEC, RegDst=1 and RegWrite=1 in RTYPEWB; Op=0x04 -> PCWriteCond=1, ALUOp=01, PCSource=01 for exactly one cycle.
REQ-031 Op=0x3F in DECODE -> IllegalOp=1 for one cycle, next State=0, no RegWrite/MemWrite assertion.
REQ-032 Op=0x08 with the macro defined -> States 0,1,10,11,0; with the macro undefined -> IllegalOp=1.
